// File: rtl/hash_ctrl_if.sv
// -----------------------------------------------------------------------------
// hash_ctrl_if
//   Bundles the round sequencer's datapath controls and the K+W scheduler
//   handshake into one interface.
//
//   Signals
//     w_vld      scheduler presents kw for round rnd
//     w_rdy      controller consumes a kw beat this cycle
//     rnd        index of the current beat, 0..N
//     fn_op      datapath input select (00 hash_i, 01 IV, 10 feed-forward, 11 zero)
//     fn_en      datapath load enable
//     kw_vld     datapath round-advance strobe
//     kw_flg0    first-beat flag
//     kw_done    drain-beat flag
//     h_flg_384  latched SHA-384 mode flag
//     hf_ld      capture hash_o into the hash_f feed-forward register
//
//   Modports
//     master     the sequencer (hash_ctrl)
//     slave      the datapath/scheduler side
// -----------------------------------------------------------------------------
interface hash_ctrl_if #(
    parameter int unsigned RND_W = 7
);
    logic             w_vld;
    logic             w_rdy;
    logic [RND_W-1:0] rnd;
    logic [1:0]       fn_op;
    logic             fn_en;
    logic             kw_vld;
    logic             kw_flg0;
    logic             kw_done;
    logic             h_flg_384;
    logic             hf_ld;

    modport master (
        input  w_vld,
        output w_rdy,
        output rnd,
        output fn_op,
        output fn_en,
        output kw_vld,
        output kw_flg0,
        output kw_done,
        output h_flg_384,
        output hf_ld
    );

    modport slave (
        output w_vld,
        input  w_rdy,
        input  rnd,
        input  fn_op,
        input  fn_en,
        input  kw_vld,
        input  kw_flg0,
        input  kw_done,
        input  h_flg_384,
        input  hf_ld
    );
endinterface

// File: rtl/hash_ctrl.sv
// -----------------------------------------------------------------------------
// hash_ctrl
//   Round sequencer for the SHA-256/SHA-384 compression datapath. Accepts a
//   block-start command, optionally loads the IV or an external hash, snapshots
//   the chaining value, runs N+1 handshaked K+W beats, performs the
//   feed-forward add and pulses done.
//
//   Build option
//     HASH_CTRL_SHA384_EN  defined: mode_384 selects 80 rounds and is latched
//                          into h_flg_384. Undefined: mode_384 is ignored,
//                          h_flg_384 stays 0 and N is fixed at 64.
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     i_start      block-start request, sampled in IDLE only
//     i_init_sel   0: load IV, 1: load hash_i, 2/3: continue (no load)
//     i_mode_384   1 selects SHA-384, sampled with i_start
//     i_clr        zero the datapath register, honoured in IDLE only
//     i_abort      cancel the operation in any state
//     o_busy       high in every state other than IDLE
//     o_done       one-cycle completion pulse
//     bus          datapath controls and scheduler handshake (master side)
// -----------------------------------------------------------------------------
module hash_ctrl #(
    parameter int unsigned RND_W = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_init_sel,
    input  logic        i_mode_384,
    input  logic        i_clr,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    hash_ctrl_if.master bus
);

    localparam logic [RND_W-1:0] N256 = RND_W'(64);
    localparam logic [RND_W-1:0] N384 = RND_W'(80);

    localparam logic [1:0] OpHashIn = 2'b00;
    localparam logic [1:0] OpIv     = 2'b01;
    localparam logic [1:0] OpFfAdd  = 2'b10;
    localparam logic [1:0] OpZero   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSnap,
        StRound,
        StFinal,
        StDone
    } state_e;

    state_e           r_state;
    logic [RND_W-1:0] r_rnd;
    logic             r_fn_en;
    logic [1:0]       r_fn_op;
    logic             r_hf_ld;
    logic             r_w_rdy;
    logic             r_busy;
    logic             r_done;
    logic             r_h_flg;

    logic             w_mode;
    logic [RND_W-1:0] w_n;
    logic             w_last;
    logic             w_beat;
    logic             w_fn_en;

`ifdef HASH_CTRL_SHA384_EN
    assign w_mode = i_mode_384;
    assign w_n    = r_h_flg ? N384 : N256;
`else
    // Mode input has no effect in a SHA-256-only build.
    assign w_mode = i_mode_384 & 1'b0;
    assign w_n    = N256;
`endif

    assign w_last = (r_rnd == w_n);

    // Outputs are registered one cycle ahead (decoded from the next state);
    // every strobe defaults low so it lasts exactly one cycle unless re-armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_rnd   <= '0;
            r_fn_en <= 1'b0;
            r_fn_op <= OpHashIn;
            r_hf_ld <= 1'b0;
            r_w_rdy <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_h_flg <= 1'b0;
        end else if (i_abort) begin
            r_state <= StIdle;
            r_rnd   <= '0;
            r_fn_en <= 1'b0;
            r_fn_op <= OpHashIn;
            r_hf_ld <= 1'b0;
            r_w_rdy <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_h_flg <= 1'b0;
        end else begin
            r_fn_en <= 1'b0;
            r_fn_op <= OpHashIn;
            r_hf_ld <= 1'b0;
            r_done  <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_busy  <= 1'b1;
                        r_h_flg <= w_mode;
                        if (!i_init_sel[1]) begin
                            r_state <= StLoad;
                            r_fn_en <= 1'b1;
                            r_fn_op <= i_init_sel[0] ? OpHashIn : OpIv;
                        end else begin
                            // Continue: hash_o already holds the chaining value.
                            r_state <= StSnap;
                            r_hf_ld <= 1'b1;
                        end
                    end else if (i_clr) begin
                        r_fn_en <= 1'b1;
                        r_fn_op <= OpZero;
                    end
                end

                StLoad: begin
                    r_state <= StSnap;
                    r_hf_ld <= 1'b1;
                end

                StSnap: begin
                    r_state <= StRound;
                    r_rnd   <= '0;
                    r_w_rdy <= 1'b1;
                end

                StRound: begin
                    // w_rdy is high for the whole state, so w_vld alone accepts a beat.
                    if (bus.w_vld) begin
                        if (w_last) begin
                            r_state <= StFinal;
                            r_rnd   <= '0;
                            r_w_rdy <= 1'b0;
                            r_fn_en <= 1'b1;
                            r_fn_op <= OpFfAdd;
                        end else begin
                            r_rnd <= r_rnd + RND_W'(1);
                        end
                    end
                end

                StFinal: begin
                    r_state <= StDone;
                    r_done  <= 1'b1;
                end

                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_h_flg <= 1'b0;
                end

                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_w_rdy <= 1'b0;
                    r_h_flg <= 1'b0;
                end
            endcase
        end
    end

    // abort masks the enables in its own cycle so the datapath never moves
    // on a cancelled operation.
    assign w_beat  = r_w_rdy & bus.w_vld & ~i_abort;
    assign w_fn_en = r_fn_en & ~i_abort;

    assign bus.w_rdy     = r_w_rdy;
    assign bus.rnd       = r_rnd;
    assign bus.fn_en     = w_fn_en;
    assign bus.fn_op     = w_fn_en ? r_fn_op : OpHashIn;
    assign bus.hf_ld     = r_hf_ld & ~i_abort;
    assign bus.kw_vld    = w_beat;
    assign bus.kw_flg0   = w_beat & (r_rnd == '0);
    assign bus.kw_done   = w_beat & w_last;
    assign bus.h_flg_384 = r_h_flg;

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_hash_ctrl.sv
module tb_hash_ctrl;

    localparam int unsigned RND_W = 7;
`ifdef HASH_CTRL_SHA384_EN
    localparam bit Sha384Built = 1'b1;
`else
    localparam bit Sha384Built = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [1:0] init_sel = 2'd0;
    logic       mode_384 = 1'b0;
    logic       clr      = 1'b0;
    logic       abort    = 1'b0;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    hash_ctrl_if #(.RND_W(RND_W)) bus ();

    hash_ctrl #(.RND_W(RND_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_init_sel (init_sel),
        .i_mode_384 (mode_384),
        .i_clr      (clr),
        .i_abort    (abort),
        .o_busy     (busy),
        .o_done     (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // {busy, done, fn_en, fn_op[1:0], hf_ld, kw_vld, kw_flg0, kw_done, h_flg_384, w_rdy}
    function automatic logic [10:0] obs_vec();
        return {busy, done, bus.fn_en, bus.fn_op, bus.hf_ld, bus.kw_vld, bus.kw_flg0,
                bus.kw_done, bus.h_flg_384, bus.w_rdy};
    endfunction

    function automatic logic [10:0] ev(input bit b, input bit d, input bit en,
                                       input logic [1:0] op, input bit hf, input bit kv,
                                       input bit f0, input bit kd, input bit h, input bit rdy);
        return {b, d, en, op, hf, kv, f0, kd, h, rdy};
    endfunction

    task automatic check_vec(input string tag, input int cyc, input logic [10:0] exp);
        logic [10:0] o;
        o = obs_vec();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b (busy,done,en,op,hf,kv,f0,kd,h,rdy)",
                   tag, cyc, o, exp);
        end
    endtask

    task automatic check_int(input string tag, input int cyc, input logic [31:0] o,
                             input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, o, e);
        end
    endtask

    // Drives one block and checks every cycle against the cycle-level rules:
    // optional LOAD, SNAP, N+1 accepted beats (stalls stretch ROUND), FINAL, DONE.
    task automatic run_block(input string tag, input logic [1:0] sel, input logic m384,
                             input int stall_pct, input int stall_at, input int abort_at,
                             input int rst_at, input bit with_clr, input bit mid_start);
        int n, ld, beats, stalls, stall_run, round_end, done_cyc, exp_done;
        bit h, vld, stopped, cut;
        n         = (m384 && Sha384Built) ? 80 : 64;
        h         = m384 && Sha384Built;
        ld        = (sel < 2'd2) ? 1 : 0;
        beats     = 0;
        stalls    = 0;
        stall_run = 0;
        round_end = 0;
        done_cyc  = -1;
        stopped   = 1'b0;
        cut       = 1'b0;

        @(negedge clk);
        start    = 1'b1;
        init_sel = sel;
        mode_384 = m384;
        clr      = with_clr;
        @(posedge clk);
        for (int c = 1; c < 400 && !stopped; c++) begin
            if (c > 1) @(posedge clk);
            #1;
            start = 1'b0;
            clr   = 1'b0;
            abort = 1'b0;
            if (c == 1) begin
                // Only sampled with start: scrambling must not matter afterwards.
                mode_384 = 1'($urandom_range(1));
                init_sel = 2'($urandom_range(3));
            end
            if (c <= ld) begin
                bus.w_vld = 1'($urandom_range(1));
                #1 check_vec({tag, ":load"}, c,
                             ev(1, 0, 1, (sel == 2'd0) ? 2'b01 : 2'b00, 0, 0, 0, 0, h, 0));
            end else if (c == ld + 1) begin
                bus.w_vld = 1'($urandom_range(1));
                #1 check_vec({tag, ":snap"}, c, ev(1, 0, 0, 2'b00, 1, 0, 0, 0, h, 0));
            end else if (round_end == 0) begin
                vld = ($urandom_range(99) >= stall_pct);
                if (beats == stall_at && stall_run < 5) begin
                    vld = 1'b0;
                    stall_run++;
                end
                bus.w_vld = vld;
                if (mid_start && beats == 20) begin
                    start = 1'b1;
                    clr   = 1'b1;
                end
                if (beats == abort_at) begin
                    abort = 1'b1;
                    #1 check_vec({tag, ":abort_cyc"}, c, ev(1, 0, 0, 2'b00, 0, 0, 0, 0, h, 1));
                    check_int({tag, ":abort_rnd"}, c, 32'(bus.rnd), beats);
                    @(posedge clk);
                    #1 abort = 1'b0;
                    #1 check_vec({tag, ":post_abort"}, c + 1, ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
                    check_int({tag, ":post_abort_rnd"}, c + 1, 32'(bus.rnd), 0);
                    stopped = 1'b1;
                    cut     = 1'b1;
                end else begin
                    #1 check_vec({tag, ":round"}, c,
                                 ev(1, 0, 0, 2'b00, 0, vld, vld && beats == 0, vld && beats == n,
                                    h, 1));
                    check_int({tag, ":rnd"}, c, 32'(bus.rnd), beats);
                    if (beats == rst_at) begin
                        #1 rst_n = 1'b0;
                        #1 check_vec({tag, ":async_rst"}, c, ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
                        check_int({tag, ":async_rst_rnd"}, c, 32'(bus.rnd), 0);
                        @(negedge clk);
                        rst_n   = 1'b1;
                        stopped = 1'b1;
                        cut     = 1'b1;
                    end else if (vld) begin
                        if (beats == n) round_end = c;
                        beats++;
                    end else begin
                        stalls++;
                    end
                end
            end else if (c == round_end + 1) begin
                bus.w_vld = 1'($urandom_range(1));
                #1 check_vec({tag, ":final"}, c, ev(1, 0, 1, 2'b10, 0, 0, 0, 0, h, 0));
            end else if (c == round_end + 2) begin
                bus.w_vld = 1'($urandom_range(1));
                #1 check_vec({tag, ":done"}, c, ev(1, 1, 0, 2'b00, 0, 0, 0, 0, h, 0));
                done_cyc = c;
            end else begin
                bus.w_vld = 1'($urandom_range(1));
                #1 check_vec({tag, ":idle"}, c, ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
                stopped = 1'b1;
            end
        end
        bus.w_vld = 1'b0;
        if (!stopped) begin
            errors++;
            checks++;
            $error("FAIL %s:timeout observed=no_idle expected=idle_within_400", tag);
        end else if (!cut) begin
            exp_done = ld + 1 + (n + 1) + stalls + 2;
            check_int({tag, ":done_latency"}, done_cyc, done_cyc, exp_done);
        end
    endtask

    initial begin
        bus.w_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_vec("reset", 0, ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
        check_int("reset_rnd", 0, 32'(bus.rnd), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // clr alone: one zeroing load, state stays IDLE.
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        #1 check_vec("clr_only", 1, ev(0, 0, 1, 2'b11, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #2 check_vec("clr_after", 2, ev(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));

        run_block("sha256",      2'd0, 1'b0, 0, -1, -1, -1, 1'b0, 1'b0);
        run_block("cont384",     2'd2, 1'b1, 0, -1, -1, -1, 1'b0, 1'b0);
        run_block("stall30",     2'd0, 1'b0, 0, 30, -1, -1, 1'b0, 1'b0);
        run_block("abort40",     2'd1, 1'b0, 0, -1, 40, -1, 1'b0, 1'b0);
        run_block("after_abort", 2'd0, 1'b0, 0, -1, -1, -1, 1'b0, 1'b0);
        run_block("clr_start",   2'd0, 1'b0, 0, -1, -1, -1, 1'b1, 1'b1);
        run_block("reset10",     2'd3, 1'b0, 0, -1, -1, 10, 1'b0, 1'b0);
        run_block("post_reset",  2'd1, 1'b1, 0, -1, -1, -1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_block("random", 2'($urandom_range(3)), 1'($urandom_range(1)), 30, -1, -1, -1,
                      1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hash_ctrl.md
# hash_ctrl

Round sequencer for the SHA-256/SHA-384 compression datapath (`hash_fn`). It accepts a block-start command and drives, cycle by cycle, the datapath's register-select and enable controls: `fn_op`, `fn_en`, `kw_vld`, `kw_flg0`, `kw_done` and `h_flg_384`. It also runs a valid/ready handshake with the K+W word scheduler and pulses `done` when the digest in `hash_o` has been updated.

## Interface
- `RND_W`, 7: width of the round index output.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: block-start request; sampled only in IDLE.
- `init_sel` input 2: start-up action, sampled with `start`.
  - 0: load the standard IV (`fn_op`=01).
  - 1: load the external `hash_i` (`fn_op`=00).
  - 2/3: continue; `hash_o` already holds the chaining value, so no load.
- `mode_384` input 1: 1 selects SHA-384 (80 rounds); sampled with `start`.
- `clr` input 1: zero the datapath register (`fn_op`=11); honoured in IDLE only.
- `abort` input 1: cancel the operation in any state.
- `w_vld` input 1: scheduler presents `kw` for round `rnd`.
- `w_rdy` output 1: controller consumes a `kw` beat this cycle.
- `rnd` output RND_W: index of the current beat, 0..N.
- `fn_op` output 2: datapath input select.
- `fn_en` output 1: datapath load enable.
- `kw_vld` output 1: datapath round-advance strobe.
- `kw_flg0` output 1: first-beat flag (zeroes maj/ch terms).
- `kw_done` output 1: drain-beat flag.
- `h_flg_384` output 1: latched mode flag.
- `hf_ld` output 1: capture `hash_o` into the `hash_f` feed-forward register.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle completion pulse.

## Operation
- States:
  - **IDLE**: waits for `start` or `clr`.
  - **LOAD**: one cycle; `fn_en`=1; `fn_op`=01 for `init_sel`=0, 00 for `init_sel`=1.
  - **SNAP**: one cycle; `hf_ld`=1.
  - **ROUND**: runs N+1 handshaked beats.
  - **FINAL**: one cycle; `fn_en`=1, `fn_op`=10 (feed-forward add).
  - **DONE**: one cycle; `done`=1; next state is IDLE.
- Transitions:
  - IDLE + `start`, `init_sel`<2 → LOAD.
  - IDLE + `start`, `init_sel`≥2 → SNAP (skips LOAD).
  - LOAD → SNAP → ROUND.
  - ROUND exits on the accepted beat with `rnd`=N, then → FINAL → DONE → IDLE.
- N = 64 when `mode_384`=0, N = 80 when `mode_384`=1. `h_flg_384` is latched at start and held until return to IDLE.
- ROUND beats:
  - `w_rdy`=1 throughout ROUND.
  - Beat accepted when `w_vld`&&`w_rdy`; `kw_vld` = `w_vld` in ROUND.
  - `rnd` increments only on an accepted beat and resets to 0 on entering ROUND.
  - `kw_flg0` = `kw_vld` && `rnd`==0.
  - `kw_done` = `kw_vld` && `rnd`==N.
  - The scheduler must present `kw`=0 on the drain beat (`rnd`=N).
- `w_vld` low in ROUND stalls the sequence: `kw_vld`=0, `rnd` holds, and the datapath holds.
- IDLE + `clr` (with `start` low): `fn_en`=1, `fn_op`=11 for one cycle; state remains IDLE. When `clr` and `start` are both high, `start` wins and `clr` is ignored.
- `abort` has priority over everything in any state:
  - Next state is IDLE; the abort cycle itself drives `fn_en`=`kw_vld`=`hf_ld`=0.
  - `done` is not pulsed and `rnd` is cleared.
  - `abort` during DONE does not suppress that cycle's `done` pulse.
- `start` outside IDLE is ignored.
- Outputs are decoded from registered state and `rnd`. The only combinational input paths are `w_vld`→`kw_vld`/`kw_flg0`/`kw_done` and `abort`→the enable outputs.

## Timing
- Reset values: state IDLE, `rnd`=0, `fn_op`=00, and `fn_en`, `kw_vld`, `kw_flg0`, `kw_done`, `h_flg_384`, `hf_ld`, `w_rdy`, `busy`, `done` all 0.
- Assertion of `rst_n` mid-operation returns to IDLE immediately (asynchronous).
- `fn_op` is 00 whenever `fn_en`=0.
- Zero-stall latency, with `start` sampled at edge 0:
  - LOAD is cycle 1, SNAP cycle 2, ROUND cycles 3..3+N, FINAL 4+N, DONE 5+N.
  - `done` is high 69 cycles after `start` for SHA-256 and 85 cycles for SHA-384.
  - Continue mode is one cycle shorter.
  - Each stall cycle adds one cycle.
- `busy` rises the cycle after `start` is accepted and falls the cycle after DONE.
- A new `start` can be accepted on the first IDLE cycle after DONE.

## Configuration
- `HASH_CTRL_SHA384_EN` defined: behaviour as described above.
- `HASH_CTRL_SHA384_EN` undefined:
  - `mode_384` is ignored and `h_flg_384` is tied to 0.
  - N is fixed at 64.
  - The round-count comparator uses the 256 limit only.

## Test plan
- Reset, then `start`, `init_sel`=0, `mode_384`=0, `w_vld` held at 1:
  - `fn_en`/`fn_op`=01 in cycle 1 and `hf_ld` in cycle 2.
  - 65 `kw_vld` beats with `kw_flg0` at `rnd`=0 and `kw_done` at `rnd`=64.
  - `fn_op`=10 in cycle 68, `done` in cycle 69.
- `mode_384`=1, `init_sel`=2: no LOAD, 81 beats, `h_flg_384`=1 throughout, `done` at cycle 84.
- Drop `w_vld` for 5 cycles at `rnd`=30: `rnd` holds at 30 and `kw_vld`=0 during the stall; `done` arrives at cycle 74.
- Assert `abort` at `rnd`=40: the next cycle shows IDLE, `rnd`=0, `busy`=0 and no `done`; a following `start` completes normally.
- `clr`+`start` together in IDLE produce LOAD with no 11 op. `clr` alone produces a single `fn_en` cycle with `fn_op`=11. A `start` pulse during ROUND is ignored.
- Drop `rst_n` at `rnd`=10: all outputs reach their reset values asynchronously.
